sr_sipo_rx: RTL
===============

# sr_sipo_rx

Serial-in, parallel-out receive stage that sits directly downstream of the team's 4-bit parallel-in/serial-out shift register. It samples the MSB-first serial bit stream under a bit-valid qualifier and reassembles WIDTH-bit words. Each completed word is presented on a registered parallel output with a valid/ready handshake. The block also reports overrun and framing errors.

## Interface
- `WIDTH`, default 4: word length in bits; legal range 2..16.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `si`  in  1: serial data, MSB first.
- `si_en`  in  1: high when `si` carries a valid bit this cycle.
- `si_sync`  in  1: frame marker; qualified by `si_en`; marks the bit on `si` as the MSB of a new word.
- `po`  out  WIDTH: assembled parallel word.
- `po_valid`  out  1: `po` holds an unconsumed word.
- `po_ready`  in  1: consumer accepts `po` when `po_valid && po_ready`.
- `overrun`  out  1: sticky; a completed word was dropped.
- `frame_err`  out  1: sticky; `si_sync` arrived with a partial word pending.

## Operation
- Reset values:
  - `po` = 0, `po_valid` = 0, `overrun` = 0, `frame_err` = 0.
  - Bit counter = 0, shift register = 0, FSM = IDLE.
- FSM states:
  - IDLE: no partial word.
  - ACC: 1..WIDTH-1 bits held.
- Shift rule: on each cycle with `si_en`=1, `shreg <= {shreg[WIDTH-2:0], si}` and `cnt <= cnt+1`. Cycles with `si_en`=0 leave state unchanged (gaps are allowed).
- IDLE→ACC: on the first qualified bit.
- ACC→IDLE: when the WIDTH-th bit is shifted in (`cnt` = WIDTH-1 with `si_en`). The word `{shreg[WIDTH-2:0], si}` completes and `cnt` wraps to 0.
- `si_sync` with `si_en`:
  - The current bit becomes bit WIDTH-1 of a new word and `cnt` becomes 1.
  - If the FSM is in ACC, the partial word is discarded and `frame_err` sets.
  - `si_sync` in IDLE is legal and silent.
  - `si_sync` without `si_en` is ignored.
  - When WIDTH=1-equivalent completion is impossible (WIDTH≥2), a sync bit never completes a word by itself.
- Output buffer (one word deep):
  - A completed word loads into `po` and sets `po_valid` if `po_valid`=0, or if `po_valid && po_ready` in the same cycle.
  - Otherwise the completed word is dropped, `po` is unchanged, and `overrun` sets.
- Handshake: `po_valid && po_ready` with no completion in that cycle clears `po_valid`. `po` keeps its value after consumption.
- `po` is stable while `po_valid`=1 and not consumed.
- `po_ready` may be high while `po_valid`=0; this has no effect.
- Sticky flags clear only on `rst`.
- Reset mid-word: any partial word and any pending output are discarded. Bits presented in the reset cycle are ignored.

## Timing
- Latency: when the last bit is sampled at edge N, `po`/`po_valid` are valid after edge N, i.e. during cycle N+1.
- Throughput: one word per WIDTH qualified bits; back-to-back words with no gap cycles are sustained if `po_ready`=1.
- Simultaneous completion and consume: the new word replaces the old one, `po_valid` stays 1, and no overrun is raised.
- Flags assert in the cycle after the causing edge, alongside the state update.
- No combinational path from inputs to outputs; all outputs are registered.

## Structure
- Package `sr_pkg`: state enum `sipo_state_t` {IDLE, ACC}; constant `SIPO_WIDTH_DEF` = 4; counter width derived as `$clog2(WIDTH)`.
- Sub-module `sipo_out_buf`: a one-entry holding register with the valid/ready handshake and overrun detection. Its inputs are the word, `word_done`, and `po_ready`. The top level holds the shift register, counter, FSM and frame logic.
- Expected RTL size is about 150–250 lines total.

## Test plan
- **Basic word:** reset, then bits 1,0,1,1 with `si_en`=1 on four consecutive cycles and `po_ready`=1 → `po`=4'b1011 and `po_valid`=1 for exactly one cycle, starting the cycle after the fourth bit.
- **Gapped input:** bits 0,1,1,0 with `si_en`=0 gaps of 0–3 cycles between them → `po`=4'b0110; no flags set.
- **Backpressure:** `po_ready`=0, send 4'b1100, then 4'b0011 → `po` stays 4'b1100 and `overrun`=1. Then raise `po_ready` → 4'b1100 is consumed and `po_valid` falls.
- **Same-cycle completion and consume:** with `po_valid` holding 4'b1010 and `po_ready`=1 on the cycle 4'b0101 completes → `po`=4'b0101, `po_valid` stays 1, `overrun`=0.
- **Resync:** send bits 1,1, then `si_sync` with bits 0,0,1,1 → `frame_err`=1 and `po`=4'b0011.
- **Reset mid-word:** send bits 1,0, assert `rst` for one cycle, then send bits 1,1,1,0 → `po`=4'b1110; all flags 0 and `po_valid` 0 during and immediately after reset.

Source files
------------

// File: rtl/sr_sipo_rx_pkg.sv
// sr_pkg: shared types and constants for the serial-in/parallel-out receive stage.
//   sipo_state_t   : framing FSM state (IDLE = no partial word, ACC = partial word held)
//   SIPO_WIDTH_DEF : default word length
//   cnt_width()    : bit-counter width for a given word length
package sr_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } sipo_state_t;

    localparam int SIPO_WIDTH_DEF = 4;

    // Counter holds 0..WIDTH-1. The guard only protects against WIDTH=1,
    // which is outside the legal range.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/sr_sipo_rx_if.sv
// sr_sipo_rx_if: serial input and parallel output bus of the SIPO receive stage.
//   si, si_en, si_sync : serial bit, bit qualifier, frame marker (MSB of a new word)
//   po, po_valid       : assembled word and its valid flag
//   po_ready           : consumer accept
//   overrun, frame_err : sticky error flags
// master drives the serial side and consumes words; slave is the receiver.
interface sr_sipo_rx_if
    import sr_pkg::*;
#(
    parameter int WIDTH = SIPO_WIDTH_DEF
);
    logic             si;
    logic             si_en;
    logic             si_sync;
    logic [WIDTH-1:0] po;
    logic             po_valid;
    logic             po_ready;
    logic             overrun;
    logic             frame_err;

    modport master (
        output si, si_en, si_sync, po_ready,
        input  po, po_valid, overrun, frame_err
    );

    modport slave (
        input  si, si_en, si_sync, po_ready,
        output po, po_valid, overrun, frame_err
    );
endinterface

// File: rtl/sr_sipo_rx_out_buf.sv
// sipo_out_buf: one-entry output holding register with valid/ready handshake.
//   clk, rst  : clock, synchronous active-high reset
//   word      : completed word from the shift register
//   word_done : word is complete this cycle
//   po_ready  : consumer accept
//   po        : held word (keeps its value after consumption)
//   po_valid  : po holds an unconsumed word
//   overrun   : sticky, a completed word was dropped because the buffer was full
module sipo_out_buf #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] word,
    input  logic             word_done,
    input  logic             po_ready,
    output logic [WIDTH-1:0] po,
    output logic             po_valid,
    output logic             overrun
);

    // Buffer can take a new word when empty or when being drained this cycle.
    logic can_load;
    assign can_load = !po_valid || po_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            po       <= '0;
            po_valid <= 1'b0;
            overrun  <= 1'b0;
        end else if (word_done) begin
            if (can_load) begin
                po       <= word;
                po_valid <= 1'b1;
            end else begin
                overrun  <= 1'b1;
            end
        end else if (po_valid && po_ready) begin
            po_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/sr_sipo_rx.sv
// sr_sipo_rx: serial-in/parallel-out receive stage. Samples an MSB-first bit
// stream qualified by si_en, reassembles WIDTH-bit words and hands them to a
// one-deep output buffer. si_sync realigns framing; realigning with a partial
// word pending raises the sticky frame_err.
//   clk, rst : clock, synchronous active-high reset
//   bus      : sr_sipo_rx_if slave (si, si_en, si_sync, po_ready in;
//              po, po_valid, overrun, frame_err out)
module sr_sipo_rx
    import sr_pkg::*;
#(
    parameter int WIDTH = SIPO_WIDTH_DEF
) (
    input  logic         clk,
    input  logic         rst,
    sr_sipo_rx_if.slave  bus
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    sipo_state_t      state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    // Only the low WIDTH-1 shifted bits are ever part of a future word, so
    // the MSB of the architectural shift register is not stored.
    logic [WIDTH-2:0] shreg, shreg_n;
    logic [WIDTH-1:0] shifted;
    logic             word_done;
    logic             set_ferr;
    logic             frame_err;

    assign shifted = {shreg, bus.si};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            shreg <= shreg_n;
            if (set_ferr)
                frame_err <= 1'b1;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        shreg_n   = shreg;
        word_done = 1'b0;
        set_ferr  = 1'b0;
        if (bus.si_en) begin
            shreg_n = shifted[WIDTH-2:0];
            if (bus.si_sync) begin
                // Sync bit starts a new word; with WIDTH>=2 it cannot complete one.
                state_n  = ACC;
                cnt_n    = CW'(1);
                set_ferr = (state == ACC);
            end else if (cnt == LAST) begin
                state_n   = IDLE;
                cnt_n     = '0;
                word_done = 1'b1;
            end else begin
                state_n = ACC;
                cnt_n   = cnt + CW'(1);
            end
        end
    end

    assign bus.frame_err = frame_err;

    sipo_out_buf #(.WIDTH(WIDTH)) u_out_buf (
        .clk       (clk),
        .rst       (rst),
        .word      (shifted),
        .word_done (word_done),
        .po_ready  (bus.po_ready),
        .po        (bus.po),
        .po_valid  (bus.po_valid),
        .overrun   (bus.overrun)
    );

endmodule
